// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with one-entry skid buffer
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN to add
// misalign_err and the HALT state. Default build clears jmp_target[1:0].
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] tgt;
  logic        transfer;
  logic        pending;

  // Redirect targets are always word aligned; the low bits never reach pc.
  assign tgt = {jmp_target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |jmp_target[1:0];
`else
  logic tgt_low_unused;
  assign tgt_low_unused = ^jmp_target[1:0];
`endif

  // Request whenever fetching or draining with room for the response; dropped during reset.
  assign imem_req  = !rst && !skid_valid && (state == FETCH || state == DRAIN);
  assign imem_addr = pc;
  assign transfer  = imem_req && imem_ready;
  // A request is outstanding and cannot be retargeted this cycle.
  assign pending   = imem_req && !imem_ready;

  // Fetch state machine, pc, skid buffer and decode-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'h0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      case (state)
        DRAIN: begin
          // Output stays a bubble until the abandoned response has been swallowed.
          instr       <= NOP_INSTR;
          instr_valid <= 1'b0;
          skid_valid  <= 1'b0;
          if (jmp_taken) redirect_pc <= tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (jmp_taken && misaligned) misalign_err <= 1'b1;
`endif
          if (imem_ready) begin
            pc    <= jmp_taken ? tgt : redirect_pc;
            state <= FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign_err || (jmp_taken && misaligned)) state <= HALT;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        HALT: begin
          instr       <= NOP_INSTR;
          instr_valid <= 1'b0;
          skid_valid  <= 1'b0;
        end
`endif
        FETCH: begin
          if (jmp_taken) begin
            // Redirect wins over stall and data, and always flushes.
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
            if (pending) begin
              redirect_pc <= tgt;
              state       <= DRAIN;
            end else begin
              pc <= tgt;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              misalign_err <= 1'b1;
              if (!pending) state <= HALT;
            end
`endif
          end else if (transfer) begin
            pc <= pc + 32'd4;
            if (!stall) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
            end else begin
              // Decode is stalled: park the word; request stops while parked.
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
            end
          end else if (!stall) begin
            if (skid_valid) begin
              instr       <= skid_instr;
              instr_pc    <= skid_pc;
              instr_valid <= 1'b1;
              skid_valid  <= 1'b0;
            end else begin
              instr       <= NOP_INSTR;
              instr_valid <= 1'b0;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jmp_taken;
  logic [31:0] jmp_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .jmp_taken   (jmp_taken),
    .jmp_target  (jmp_target),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is its address xor a fixed salt.
  assign imem_rdata = imem_addr ^ SALT;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc_exp);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc_exp);
    chk({tag, "_instr"}, instr, pc_exp ^ SALT);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; jmp_taken = 1'b0; jmp_target = 32'h0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming with ready tied high.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("stream", 32'(4 * k));
    end
    chk("stream_addr", imem_addr, 32'h10);

    // Stall three cycles: 0x0C holds, 0x10 parks in the skid.
    stall = 1'b1;
    tick();
    chk_out("stall1", 32'h0C);
    chk("stall1_req", {31'b0, imem_req}, 32'd0);
    chk("stall1_addr", imem_addr, 32'h14);
    tick(); tick();
    chk_out("stall3", 32'h0C);
    chk("stall3_req", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk_out("skid_out", 32'h10);
    chk("skid_req", {31'b0, imem_req}, 32'd1);
    tick();
    chk_out("after_skid", 32'h14);
    tick(); tick();
    chk_out("pre_jmp", 32'h1C);
    chk("pre_jmp_addr", imem_addr, 32'h20);

    // Redirect on a transfer cycle: 0x20 dropped, one bubble.
    jmp_taken = 1'b1; jmp_target = 32'h100;
    tick();
    jmp_taken = 1'b0;
    chk("jmp_valid", {31'b0, instr_valid}, 32'd0);
    chk("jmp_instr", instr, NOP);
    chk("jmp_addr", imem_addr, 32'h100);
    tick();
    chk_out("jmp_land", 32'h100);

    // Redirect while a request is stuck: address must not move until ready.
    imem_ready = 1'b0;
    tick();
    chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    jmp_taken = 1'b1; jmp_target = 32'h200;
    tick();
    jmp_taken = 1'b0;
    chk("drain_addr1", imem_addr, 32'h104);
    chk("drain_req1", {31'b0, imem_req}, 32'd1);
    tick(); tick();
    chk("drain_addr3", imem_addr, 32'h104);
    chk("drain_valid", {31'b0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    chk("drain_done_valid", {31'b0, instr_valid}, 32'd0);
    chk("drain_done_addr", imem_addr, 32'h200);
    tick();
    chk_out("drain_land", 32'h200);

    // Redirect while stalled with the skid full.
    stall = 1'b1;
    tick();
    chk("skidfull_req", {31'b0, imem_req}, 32'd0);
    jmp_taken = 1'b1; jmp_target = 32'h40;
    tick();
    jmp_taken = 1'b0;
    chk("skidflush_valid", {31'b0, instr_valid}, 32'd0);
    chk("skidflush_req", {31'b0, imem_req}, 32'd1);
    chk("skidflush_addr", imem_addr, 32'h40);
    stall = 1'b0;
    tick();
    chk_out("skidflush_land", 32'h40);

    // Low target bits are cleared.
    jmp_taken = 1'b1; jmp_target = 32'h303;
    tick();
    jmp_taken = 1'b0;
    chk("align_addr", imem_addr, 32'h300);
    tick();
    chk_out("align_land", 32'h300);

    // pc wraps at the top of the address space.
    jmp_taken = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick();
    jmp_taken = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk_out("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0);
    tick();
    chk_out("wrap_zero", 32'h0);

    // Redirects during DRAIN overwrite; the completion-cycle target wins.
    imem_ready = 1'b0; jmp_taken = 1'b1; jmp_target = 32'h500;
    tick();
    jmp_target = 32'h600;
    tick();
    chk("drain2_addr", imem_addr, 32'h4);
    imem_ready = 1'b1; jmp_target = 32'h700;
    tick();
    jmp_taken = 1'b0;
    chk("drain2_addr_new", imem_addr, 32'h700);
    tick();
    chk_out("drain2_land", 32'h700);

    // Reset in the middle of a request drops it at once.
    imem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, imem_req}, 32'd0);
    chk("rst_mid_addr", imem_addr, 32'h0);
    chk("rst_mid_valid", {31'b0, instr_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
